// File: rtl/hiscore_ram_arbiter_if.sv
// Bus bundle shared by the game CPU, the hiscore engine, the work-RAM port and the arbiter.
interface hiscore_ram_arbiter_if #(
    parameter int AW = 10
);
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_dout;
    logic          cpu_we;
    logic [7:0]    cpu_din;
    logic          cpu_pause;

    logic          hs_req;
    logic          hs_gnt;
    logic [AW-1:0] hs_addr;
    logic [7:0]    hs_dout;
    logic          hs_we;
    logic [7:0]    hs_din;
    logic          hs_abort;

    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_data;
    logic          ram_we;
    logic [7:0]    ram_q;

    modport slave (
        input  cpu_addr, cpu_dout, cpu_we, hs_req, hs_addr, hs_dout, hs_we, ram_q,
        output cpu_din, cpu_pause, hs_gnt, hs_din, hs_abort, ram_addr, ram_data, ram_we
    );

    modport master (
        output cpu_addr, cpu_dout, cpu_we, hs_req, hs_addr, hs_dout, hs_we, ram_q,
        input  cpu_din, cpu_pause, hs_gnt, hs_din, hs_abort, ram_addr, ram_data, ram_we
    );
endinterface

// File: rtl/hiscore_ram_arbiter.sv
// Work-RAM port arbiter between the game CPU and the hiscore load/save engine.
// Optional grant watchdog: define HISCORE_ARB_WATCHDOG_EN.
//
// state   | meaning
// IDLE    | CPU owns the port, waiting for hs_req
// PAUSE   | CPU paused, in-flight CPU cycle settling (SETTLE cycles)
// GRANT   | hiscore engine owns the port
// RELEASE | one dead cycle, CPU routed but writes blocked, still paused
// HOLDOFF | CPU runs unpaused for CPU_SLICE cycles before a new request
module hiscore_ram_arbiter #(
    parameter int AW        = 10,
    parameter int SETTLE    = 2,
    parameter int CPU_SLICE = 16,
    parameter int MAX_HOLD  = 1024
) (
    input logic                  clk,
    input logic                  reset_n,
    hiscore_ram_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PAUSE   = 3'd1,
        GRANT   = 3'd2,
        RELEASE = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    localparam int CNT_MAX = (CPU_SLICE > SETTLE) ? CPU_SLICE : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] SLICE_LAST  = CNT_W'((CPU_SLICE > 0) ? CPU_SLICE - 1 : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pause_q, gnt_q;
    logic             abort_blk;
    logic [AW-1:0]    addr_sel;

`ifdef HISCORE_ARB_WATCHDOG_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              abort_q, abort_d;
    assign abort_blk = abort_q;
`else
    assign abort_blk = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pause_q <= 1'b0;
            gnt_q   <= 1'b0;
`ifdef HISCORE_ARB_WATCHDOG_EN
            hold_q  <= '0;
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pause_q <= (state_d == PAUSE) || (state_d == GRANT) || (state_d == RELEASE);
            gnt_q   <= (state_d == GRANT);
`ifdef HISCORE_ARB_WATCHDOG_EN
            hold_q  <= hold_d;
            abort_q <= abort_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef HISCORE_ARB_WATCHDOG_EN
        hold_d  = hold_q;
        abort_d = abort_q && bus.hs_req;
`endif
        case (state_q)
            IDLE: begin
                if (bus.hs_req && !abort_blk) begin
                    state_d = PAUSE;
                    cnt_d   = '0;
                end
            end
            PAUSE: begin
                // A withdrawn request wins over the final settle count.
                if (!bus.hs_req) begin
                    state_d = RELEASE;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = GRANT;
`ifdef HISCORE_ARB_WATCHDOG_EN
                    hold_d  = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GRANT: begin
                if (!bus.hs_req) begin
                    state_d = RELEASE;
`ifdef HISCORE_ARB_WATCHDOG_EN
                end else if (hold_q == HOLD_LAST) begin
                    state_d = RELEASE;
                    abort_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
`endif
                end
            end
            RELEASE: begin
                cnt_d   = '0;
                state_d = (CPU_SLICE > 0) ? HOLDOFF : IDLE;
            end
            HOLDOFF: begin
                if (cnt_q == SLICE_LAST) state_d = IDLE;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // gnt_q doubles as the registered owner bit for the port mux.
    always_comb begin
        addr_sel     = bus.cpu_addr;
        bus.ram_data = bus.cpu_dout;
        bus.ram_we   = bus.cpu_we;
        if (gnt_q) begin
            addr_sel     = bus.hs_addr;
            bus.ram_data = bus.hs_dout;
            bus.ram_we   = bus.hs_we;
        end else if (state_q == RELEASE) begin
            bus.ram_we   = 1'b0;
        end
    end

    assign bus.ram_addr  = addr_sel;
    assign bus.cpu_din   = bus.ram_q;
    assign bus.hs_din    = bus.ram_q;
    assign bus.cpu_pause = pause_q;
    assign bus.hs_gnt    = gnt_q;
`ifdef HISCORE_ARB_WATCHDOG_EN
    assign bus.hs_abort  = abort_q;
`else
    assign bus.hs_abort  = 1'b0;
`endif
endmodule
